// File: rtl/cpu_pkg.sv
// Shared CPU constants and the write-back entry type used by the
// write-back unit and its collision FIFO.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  typedef struct packed {
    logic [REG_AW-1:0] reg_addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Collision FIFO for write-back entries: two push ports per cycle
// (push0 lands first), one pop port, and an occupancy count.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push0,
  input  wb_entry_t                  push0_data,
  input  logic                       push1,
  input  wb_entry_t                  push1_data,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_nx1;
  logic [CNT_W-1:0]  count_q;
  logic [1:0]        n_push;
  wb_entry_t         first_data;

  assign n_push     = {1'b0, push0} + {1'b0, push1};
  assign first_data = push0 ? push0_data : push1_data;
  assign wr_ptr_nx1 = wr_ptr + PTR_W'(1);
  assign head       = mem[rd_ptr];
  assign count      = count_q;

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push0 || push1) mem[wr_ptr] <= first_data;
    if (push0 && push1) mem[wr_ptr_nx1] <= push1_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(n_push);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Serialises ALU and load results onto the single register-file write
// port, queues collisions, and tracks pending writes for RAW stalls.
module writeback_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [REG_AW-1:0]       alu_reg,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    ls_valid,
  output logic                    ls_ready,
  input  logic [REG_AW-1:0]       ls_reg,
  input  logic [DATA_W-1:0]       ls_data,
  input  logic                    issue_valid,
  input  logic [REG_AW-1:0]       issue_reg,
  input  logic                    rd_en,
  input  logic [REG_AW-1:0]       rdReg1,
  input  logic [REG_AW-1:0]       rdReg2,
  output logic                    stall,
  output logic                    wr1,
  output logic [REG_AW-1:0]       wrReg1,
  output logic [DATA_W-1:0]       wrData1,
  output logic [2**REG_AW-1:0]    pending,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 2**REG_AW;

  logic             ready;
  logic             ls_acc;
  logic             alu_acc;
  logic             fifo_has;
  logic [CNT_W-1:0] count;
  wb_entry_t        ls_ent;
  wb_entry_t        alu_ent;
  wb_entry_t        head;
  wb_entry_t        sel;
  logic             sel_valid;
  logic             pop;
  logic             push0;
  logic             push1;
  wb_entry_t        push0_data;
  wb_entry_t        push1_data;
  logic [NREG-1:0]  pending_q;
  logic [NREG-1:0]  pending_nx;

  assign ready      = (count != CNT_W'(DEPTH));
  assign alu_ready  = ready;
  assign ls_ready   = ready;
  assign ls_acc     = ls_valid & ready;
  assign alu_acc    = alu_valid & ready;
  assign fifo_has   = (count != '0);
  assign fifo_count = count;
  assign ls_ent     = '{reg_addr: ls_reg, data: ls_data};
  assign alu_ent    = '{reg_addr: alu_reg, data: alu_data};

  // Older queued entries always go first, which keeps acceptance order
  // across registers; within a cycle LS is ordered before ALU.
  always_comb begin
    sel        = head;
    sel_valid  = 1'b0;
    pop        = 1'b0;
    push0      = 1'b0;
    push1      = 1'b0;
    push0_data = ls_ent;
    push1_data = alu_ent;
    if (fifo_has) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
      push0     = ls_acc;
      push1     = alu_acc;
    end else if (ls_acc) begin
      sel        = ls_ent;
      sel_valid  = 1'b1;
      push0      = alu_acc;
      push0_data = alu_ent;
    end else if (alu_acc) begin
      sel       = alu_ent;
      sel_valid = 1'b1;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0      (push0),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_data (push1_data),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr1     <= 1'b0;
      wrReg1  <= '0;
      wrData1 <= '0;
    end else begin
      wr1 <= sel_valid;
      if (sel_valid) begin
        wrReg1  <= sel.reg_addr;
        wrData1 <= sel.data;
      end
    end
  end

  // Set is applied after clear so a same-edge issue keeps the bit.
  always_comb begin
    pending_nx = pending_q;
    if (wr1) pending_nx[wrReg1] = 1'b0;
    if (issue_valid) pending_nx[issue_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_nx;
  end

  assign pending = pending_q;
  assign stall   = rd_en & (pending_q[rdReg1] | pending_q[rdReg2]);

endmodule
